// File: rtl/reed_solomon_decoder_pkg.sv
// Shared constants and types for the Reed-Solomon decoder front-end gearbox FIFO.
package reed_solomon_decoder_pkg;

    localparam int unsigned RS_BYTE_W      = 8;
    localparam int unsigned RS_IN_BYTES    = 64;
    localparam int unsigned RS_OUT_BYTES   = 1;
    localparam int unsigned RS_DEPTH_BYTES = 512;

    // Bit positions inside err_flags
    typedef enum int unsigned {
        ERR_OVERFLOW  = 0,
        ERR_UNDERFLOW = 1,
        ERR_BAD_LEN   = 2
    } rs_err_bit_e;

endpackage

// File: rtl/reed_solomon_decoder_gearbox_ram.sv
// Byte-array storage: IN_BYTES-wide masked write port and OUT_BYTES-wide
// asynchronous read port, both addressed modulo DEPTH_BYTES.
module reed_solomon_decoder_gearbox_ram
    import reed_solomon_decoder_pkg::*;
#(
    parameter int unsigned IN_BYTES    = RS_IN_BYTES,
    parameter int unsigned OUT_BYTES   = RS_OUT_BYTES,
    parameter int unsigned DEPTH_BYTES = RS_DEPTH_BYTES
) (
    input  logic                              clk,
    input  logic                              wr_en,
    input  logic [$clog2(DEPTH_BYTES)-1:0]    wr_base,
    input  logic [$clog2(IN_BYTES):0]         wr_len,
    input  logic [RS_BYTE_W*IN_BYTES-1:0]     wr_data,
    input  logic [$clog2(DEPTH_BYTES)-1:0]    rd_base,
    output logic [RS_BYTE_W*OUT_BYTES-1:0]    rd_data
);

    localparam int unsigned AW = $clog2(DEPTH_BYTES);

    logic [RS_BYTE_W-1:0] mem [DEPTH_BYTES];

    // Masked byte write: only lanes below wr_len land; addresses wrap past the top
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < IN_BYTES; i++) begin
                if (i < 32'(wr_len)) begin
                    mem[wr_base + AW'(i)] <= wr_data[RS_BYTE_W*i +: RS_BYTE_W];
                end
            end
        end
    end

    // Fall-through read of the OUT_BYTES oldest bytes, wrapping past the top
    always_comb begin
        rd_data = '0;
        for (int unsigned j = 0; j < OUT_BYTES; j++) begin
            rd_data[RS_BYTE_W*j +: RS_BYTE_W] = mem[rd_base + AW'(j)];
        end
    end

endmodule

// File: rtl/reed_solomon_decoder_gearbox_fifo.sv
// Byte-granular width-converting FWFT FIFO feeding the RS decoder byte stream.
// Accepts partial beats of up to IN_BYTES bytes, delivers OUT_BYTES words.
// Optional sticky error flags: define REED_SOLOMON_DECODER_GEARBOX_ERR_EN.
module reed_solomon_decoder_gearbox_fifo
    import reed_solomon_decoder_pkg::*;
#(
    parameter int unsigned IN_BYTES    = RS_IN_BYTES,
    parameter int unsigned OUT_BYTES   = RS_OUT_BYTES,
    parameter int unsigned DEPTH_BYTES = RS_DEPTH_BYTES
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              flush,
    input  logic [RS_BYTE_W*IN_BYTES-1:0]     enq_data,
    input  logic [$clog2(IN_BYTES):0]         enq_len,
    input  logic                              enq_en,
    output logic                              enq_ready,
    output logic [RS_BYTE_W*OUT_BYTES-1:0]    deq_data,
    output logic                              deq_valid,
    input  logic                              deq_en,
    output logic [$clog2(DEPTH_BYTES):0]      level,
    output logic [$clog2(DEPTH_BYTES):0]      free
`ifdef REED_SOLOMON_DECODER_GEARBOX_ERR_EN
    ,
    output logic [2:0]                        err_flags
`endif
);

    localparam int unsigned AW = $clog2(DEPTH_BYTES);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned LW = $clog2(IN_BYTES) + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] level_q, level_d;

    logic len_ok;
    logic enq_acc;
    logic deq_acc;
    logic wr_en;

    // Handshake is derived from the registered level only
    assign level     = level_q;
    assign free      = CW'(DEPTH_BYTES) - level_q;
    assign enq_ready = free >= CW'(IN_BYTES);
    assign deq_valid = level_q >= CW'(OUT_BYTES);

    assign len_ok  = (enq_len != '0) && (enq_len <= LW'(IN_BYTES));
    assign enq_acc = enq_en && enq_ready && len_ok;
    assign deq_acc = deq_en && deq_valid;
    assign wr_en   = enq_acc && !flush;

    // Next pointers and level; flush discards the whole cycle's traffic
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (enq_acc) begin
                wr_ptr_d = wr_ptr_d + AW'(enq_len);
                level_d  = level_d + CW'(enq_len);
            end
            if (deq_acc) begin
                rd_ptr_d = rd_ptr_d + AW'(OUT_BYTES);
                level_d  = level_d - CW'(OUT_BYTES);
            end
        end
    end

    // Pointer and level registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

`ifdef REED_SOLOMON_DECODER_GEARBOX_ERR_EN
    logic [2:0] err_q, err_d;

    assign err_flags = err_q;

    // Sticky protocol-violation flags, cleared by flush
    always_comb begin
        err_d = err_q;
        if (flush) begin
            err_d = '0;
        end else begin
            if (enq_en && !enq_ready)              err_d[ERR_OVERFLOW]  = 1'b1;
            if (deq_en && !deq_valid)              err_d[ERR_UNDERFLOW] = 1'b1;
            if (enq_en && enq_len > LW'(IN_BYTES)) err_d[ERR_BAD_LEN]   = 1'b1;
        end
    end

    // Error flag register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_q <= '0;
        else       err_q <= err_d;
    end
`endif

    reed_solomon_decoder_gearbox_ram #(
        .IN_BYTES    (IN_BYTES),
        .OUT_BYTES   (OUT_BYTES),
        .DEPTH_BYTES (DEPTH_BYTES)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_base (wr_ptr_q),
        .wr_len  (enq_len),
        .wr_data (enq_data),
        .rd_base (rd_ptr_q),
        .rd_data (deq_data)
    );

endmodule

// File: tb/tb_reed_solomon_decoder_gearbox_fifo.sv
// Bench for the gearbox FIFO: instance 0 is 64:1, instance 1 is 64:4, both 512 deep.
// A byte-queue model predicts every output each cycle; directed steps pin literals.
module tb_reed_solomon_decoder_gearbox_fifo;

    localparam int IN    = 64;
    localparam int DEPTH = 512;

    logic clk = 1'b0;
    logic reset;

    logic         s_flush    [2];
    logic         s_enq_en   [2];
    logic         s_deq_en   [2];
    logic [511:0] s_enq_data [2];
    logic [6:0]   s_enq_len  [2];
    logic         s_enq_ready[2];
    logic         s_deq_valid[2];
    logic [9:0]   s_level    [2];
    logic [9:0]   s_free     [2];
    logic [7:0]   a_deq_data;
    logic [31:0]  b_deq_data;
    logic [2:0]   s_err      [2];

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [2:0] me[2];

    always #5 clk = ~clk;

    reed_solomon_decoder_gearbox_fifo #(
        .IN_BYTES(64), .OUT_BYTES(1), .DEPTH_BYTES(512)
    ) u_dut_a (
        .clk(clk), .reset(reset), .flush(s_flush[0]),
        .enq_data(s_enq_data[0]), .enq_len(s_enq_len[0]), .enq_en(s_enq_en[0]),
        .enq_ready(s_enq_ready[0]), .deq_data(a_deq_data), .deq_valid(s_deq_valid[0]),
        .deq_en(s_deq_en[0]), .level(s_level[0]), .free(s_free[0])
`ifdef REED_SOLOMON_DECODER_GEARBOX_ERR_EN
        , .err_flags(s_err[0])
`endif
    );

    reed_solomon_decoder_gearbox_fifo #(
        .IN_BYTES(64), .OUT_BYTES(4), .DEPTH_BYTES(512)
    ) u_dut_b (
        .clk(clk), .reset(reset), .flush(s_flush[1]),
        .enq_data(s_enq_data[1]), .enq_len(s_enq_len[1]), .enq_en(s_enq_en[1]),
        .enq_ready(s_enq_ready[1]), .deq_data(b_deq_data), .deq_valid(s_deq_valid[1]),
        .deq_en(s_deq_en[1]), .level(s_level[1]), .free(s_free[1])
`ifdef REED_SOLOMON_DECODER_GEARBOX_ERR_EN
        , .err_flags(s_err[1])
`endif
    );

    function automatic int ob(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a plain byte queue per instance, updated from the inputs seen at each edge
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            qa.delete();
            qb.delete();
            me[0] = '0;
            me[1] = '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                int  sz;
                int  len;
                bit  ea;
                bit  da;
                sz  = (k == 0) ? qa.size() : qb.size();
                len = int'(s_enq_len[k]);
                ea  = s_enq_en[k] && (DEPTH - sz >= IN) && len != 0 && len <= IN;
                da  = s_deq_en[k] && sz >= ob(k);
                if (s_flush[k]) begin
                    if (k == 0) qa.delete(); else qb.delete();
                    me[k] = '0;
                end else begin
                    if (s_enq_en[k] && (DEPTH - sz < IN)) me[k][0] = 1'b1;
                    if (s_deq_en[k] && sz < ob(k))        me[k][1] = 1'b1;
                    if (s_enq_en[k] && len > IN)          me[k][2] = 1'b1;
                    if (da) begin
                        for (int j = 0; j < ob(k); j++) begin
                            if (k == 0) void'(qa.pop_front()); else void'(qb.pop_front());
                        end
                    end
                    if (ea) begin
                        for (int i = 0; i < len; i++) begin
                            if (k == 0) qa.push_back(s_enq_data[k][8*i +: 8]);
                            else        qb.push_back(s_enq_data[k][8*i +: 8]);
                        end
                    end
                end
            end
        end
    end

    // Compare every output against the model on the falling edge
    always @(negedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                int sz;
                sz = (k == 0) ? qa.size() : qb.size();
                check($sformatf("level%0d", k), 64'(s_level[k]), 64'(sz));
                check($sformatf("free%0d", k), 64'(s_free[k]), 64'(DEPTH - sz));
                check($sformatf("enq_ready%0d", k), 64'(s_enq_ready[k]), 64'(DEPTH - sz >= IN));
                check($sformatf("deq_valid%0d", k), 64'(s_deq_valid[k]), 64'(sz >= ob(k)));
`ifdef REED_SOLOMON_DECODER_GEARBOX_ERR_EN
                check($sformatf("err%0d", k), 64'(s_err[k]), 64'(me[k]));
`endif
            end
            if (qa.size() >= 1) check("deq_data0", 64'(a_deq_data), 64'(qa[0]));
            if (qb.size() >= 4) check("deq_data1", 64'(b_deq_data), 64'({qb[3], qb[2], qb[1], qb[0]}));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        s_flush[k]  = 1'b0;
        s_enq_en[k] = 1'b0;
        s_deq_en[k] = 1'b0;
        s_enq_len[k] = '0;
    endtask

    task automatic beat(input int k, input int len, input int base);
        for (int i = 0; i < IN; i++) s_enq_data[k][8*i +: 8] = 8'(base + i);
        s_enq_len[k] = 7'(len);
        s_enq_en[k]  = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            idle(k);
            s_enq_data[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // reset state
        check("rst_level", 64'(s_level[0]), 64'd0);
        check("rst_free", 64'(s_free[0]), 64'd512);
        check("rst_ready", 64'(s_enq_ready[0]), 64'd1);
        check("rst_valid", 64'(s_deq_valid[0]), 64'd0);

        // fill with 8 full beats, then a 9th is refused
        for (int b = 0; b < 8; b++) begin
            beat(0, 64, b * 64);
            cyc();
        end
        check("full_level", 64'(s_level[0]), 64'd512);
        check("full_free", 64'(s_free[0]), 64'd0);
        check("full_ready", 64'(s_enq_ready[0]), 64'd0);
        beat(0, 64, 8'h77);
        cyc();
        idle(0);
        check("ninth_level", 64'(s_level[0]), 64'd512);

        // drain in order, then one extra dequeue on empty
        s_deq_en[0] = 1'b1;
        for (int n = 0; n < 512; n++) begin
            check("drain_byte", 64'(a_deq_data), 64'(n % 256));
            cyc();
        end
        cyc();
        idle(0);
        check("empty_level", 64'(s_level[0]), 64'd0);
        check("empty_valid", 64'(s_deq_valid[0]), 64'd0);

        // zero and oversize lengths are no-ops
        beat(0, 65, 0);
        cyc();
        beat(0, 0, 0);
        cyc();
        idle(0);
        check("badlen_level", 64'(s_level[0]), 64'd0);

        // move both pointers to 500, then a beat straddling the top
        for (int b = 0; b < 7; b++) begin
            beat(0, 64, b);
            cyc();
        end
        beat(0, 52, 200);
        cyc();
        idle(0);
        check("pre_wrap_level", 64'(s_level[0]), 64'd500);
        s_deq_en[0] = 1'b1;
        repeat (500) cyc();
        idle(0);
        beat(0, 64, 8'h40);
        cyc();
        idle(0);
        check("wrap_level", 64'(s_level[0]), 64'd64);
        s_deq_en[0] = 1'b1;
        for (int i = 0; i < 64; i++) begin
            check("wrap_byte", 64'(a_deq_data), 64'(8'h40 + i));
            cyc();
        end
        idle(0);

        // simultaneous enqueue and dequeue at level 100
        beat(0, 64, 0);
        cyc();
        beat(0, 36, 100);
        cyc();
        idle(0);
        check("lvl100", 64'(s_level[0]), 64'd100);
        beat(0, 64, 8'h10);
        s_deq_en[0] = 1'b1;
        cyc();
        check("simul_level", 64'(s_level[0]), 64'd163);

        // flush wins over a concurrent enqueue and dequeue
        s_flush[0] = 1'b1;
        cyc();
        idle(0);
        check("flush_level", 64'(s_level[0]), 64'd0);
        check("flush_valid", 64'(s_deq_valid[0]), 64'd0);
        beat(0, 1, 8'h5A);
        cyc();
        idle(0);
        check("post_flush_data", 64'(a_deq_data), 64'h5A);
        check("post_flush_level", 64'(s_level[0]), 64'd1);

        // asynchronous reset in the middle of traffic
        beat(0, 64, 0);
        cyc();
        beat(0, 64, 64);
        #2 reset = 1'b1;
        #1;
        check("async_rst_level", 64'(s_level[0]), 64'd0);
        check("async_rst_valid", 64'(s_deq_valid[0]), 64'd0);
        idle(0);
        @(negedge clk);
        reset = 1'b0;
        cyc();
        check("after_rst_level", 64'(s_level[0]), 64'd0);

        // 64:4 instance: partial beats, words, residue
        beat(1, 6, 0);
        cyc();
        beat(1, 3, 6);
        cyc();
        idle(1);
        check("b_level9", 64'(s_level[1]), 64'd9);
        check("b_word0", 64'(b_deq_data), 64'h03020100);
        s_deq_en[1] = 1'b1;
        cyc();
        check("b_word1", 64'(b_deq_data), 64'h07060504);
        cyc();
        cyc();
        idle(1);
        check("b_residue_level", 64'(s_level[1]), 64'd1);
        check("b_residue_valid", 64'(s_deq_valid[1]), 64'd0);
        beat(1, 3, 9);
        cyc();
        idle(1);
        check("b_word2", 64'(b_deq_data), 64'h0B0A0908);

`ifdef REED_SOLOMON_DECODER_GEARBOX_ERR_EN
        s_flush[0] = 1'b1;
        cyc();
        idle(0);
        check("err_clear0", 64'(s_err[0]), 64'd0);
        for (int b = 0; b < 7; b++) begin
            beat(0, 64, b);
            cyc();
        end
        beat(0, 54, 0);
        cyc();
        idle(0);
        check("err_free10", 64'(s_free[0]), 64'd10);
        beat(0, 64, 0);
        cyc();
        idle(0);
        check("err_overflow", 64'(s_err[0]), 64'b001);
        s_flush[0] = 1'b1;
        cyc();
        idle(0);
        s_deq_en[0] = 1'b1;
        cyc();
        idle(0);
        check("err_underflow", 64'(s_err[0]), 64'b010);
        beat(0, 65, 0);
        cyc();
        idle(0);
        check("err_badlen", 64'(s_err[0]), 64'b110);
        s_flush[0] = 1'b1;
        cyc();
        idle(0);
        check("err_flushed", 64'(s_err[0]), 64'd0);
`endif

        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
